// File: rtl/fact_req_seq.sv
// Request sequencer around the iterative factorial core: buffers n values in a FIFO.
// It resolves n=0 and n>MAX_N locally and runs the core for the rest. Each result goes back tagged.
module fact_req_seq #(
  parameter int N_WIDTH   = 8,
  parameter int FN_WIDTH  = 32,
  parameter int TAG_WIDTH = 4,
  parameter int DEPTH     = 4,
  parameter int MAX_N     = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic [N_WIDTH-1:0]   i_req_n,
  input  logic [TAG_WIDTH-1:0] i_req_tag,
  output logic                 o_resp_valid,
  input  logic                 i_resp_ready,
  output logic [FN_WIDTH-1:0]  o_resp_fn,
  output logic                 o_resp_ovf,
  output logic [TAG_WIDTH-1:0] o_resp_tag,
  output logic                 o_core_start,
  output logic [N_WIDTH-1:0]   o_core_n,
  input  logic                 i_core_done,
  input  logic [FN_WIDTH-1:0]  i_core_fn,
  output logic [2:0]           o_dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [N_WIDTH-1:0] N_MAX = N_WIDTH'(MAX_N);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_t;

  // Handshakes: a transfer happens on any rising clk edge where valid and ready are both high;
  // a producer holds valid and its payload stable until that edge.

  state_t               r_state;
  logic [N_WIDTH-1:0]   r_fifo_n   [DEPTH];
  logic [TAG_WIDTH-1:0] r_fifo_tag [DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_count;
  logic [N_WIDTH-1:0]   r_n_reg;
  logic [TAG_WIDTH-1:0] r_tag_reg;
  logic                 r_core_start;
  logic                 r_resp_valid;
  logic [FN_WIDTH-1:0]  r_resp_fn;
  logic                 r_resp_ovf;
  logic [TAG_WIDTH-1:0] r_resp_tag;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_empty;
  logic [N_WIDTH-1:0]   w_head_n;
  logic [TAG_WIDTH-1:0] w_head_tag;
  logic                 w_head_zero;
  logic                 w_head_big;

  // Ready looks only at the registered count, never at a same-cycle pop.
  assign o_req_ready = !rst && (r_count != CNT_FULL);
  assign w_push      = i_req_valid && o_req_ready;
  assign w_empty     = (r_count == '0);
  assign w_head_n    = r_fifo_n[r_rd_ptr];
  assign w_head_tag  = r_fifo_tag[r_rd_ptr];
  assign w_head_zero = (w_head_n == '0);
  assign w_head_big  = (w_head_n > N_MAX);

  always_comb begin
    w_pop = 1'b0;
    if (r_state == IDLE && !w_empty)
      w_pop = w_head_zero || w_head_big || i_core_done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo_n[r_wr_ptr]   <= i_req_n;
        r_fifo_tag[r_wr_ptr] <= i_req_tag;
        r_wr_ptr             <= r_wr_ptr + AW'(1);
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_n_reg      <= '0;
      r_tag_reg    <= '0;
      r_core_start <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_fn    <= '0;
      r_resp_ovf   <= 1'b0;
      r_resp_tag   <= '0;
    end else begin
      r_core_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            if (w_head_zero || w_head_big) begin
              r_resp_fn    <= w_head_zero ? FN_WIDTH'(1) : '0;
              r_resp_ovf   <= w_head_big;
              r_resp_tag   <= w_head_tag;
              r_resp_valid <= 1'b1;
              r_state      <= RESP;
            end else begin
              r_n_reg      <= w_head_n;
              r_tag_reg    <= w_head_tag;
              r_core_start <= 1'b1;
              r_state      <= ISSUE;
            end
          end
        end
        ISSUE:     r_state <= WAIT_BUSY;
        WAIT_BUSY: if (!i_core_done) r_state <= WAIT_DONE;
        WAIT_DONE: begin
          if (i_core_done) begin
            r_resp_fn    <= i_core_fn;
            r_resp_ovf   <= 1'b0;
            r_resp_tag   <= r_tag_reg;
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end
        end
        RESP: begin
          if (i_resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_core_start = r_core_start;
  assign o_core_n     = r_n_reg;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_fn    = r_resp_fn;
  assign o_resp_ovf   = r_resp_ovf;
  assign o_resp_tag   = r_resp_tag;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_fact_req_seq.sv
// Bench for fact_req_seq with a behavioural iterative factorial core attached.
// Expected responses are queued at request time; a forked monitor checks them when they appear.
module tb_fact_req_seq;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_n;
  logic [3:0]  req_tag;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_fn;
  logic        resp_ovf;
  logic [3:0]  resp_tag;
  logic        core_start;
  logic [7:0]  core_n;
  logic        core_done;
  logic [31:0] core_fn;
  logic [2:0]  dbg_state;

  typedef struct packed {
    logic [31:0] lat;
    logic [31:0] fn;
    logic        ovf;
    logic [3:0]  tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   cyc;
  int   start_cnt;

  fact_req_seq dut (
    .clk          (clk),
    .rst          (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_n      (req_n),
    .i_req_tag    (req_tag),
    .o_resp_valid (resp_valid),
    .i_resp_ready (resp_ready),
    .o_resp_fn    (resp_fn),
    .o_resp_ovf   (resp_ovf),
    .o_resp_tag   (resp_tag),
    .o_core_start (core_start),
    .o_core_n     (core_n),
    .i_core_done  (core_done),
    .i_core_fn    (core_fn),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- core model: one load cycle, n multiply cycles, one exit cycle ----------------
  typedef enum logic [1:0] {C_IDLE, C_LOAD, C_MUL} cstate_t;
  cstate_t     c_state;
  logic [31:0] c_acc;
  logic [7:0]  c_cnt;

  always @(posedge clk) begin
    if (rst) begin
      c_state <= C_IDLE;
      c_acc   <= 32'd0;
      c_cnt   <= 8'd0;
    end else begin
      case (c_state)
        C_IDLE: if (core_start) c_state <= C_LOAD;
        C_LOAD: begin
          c_acc   <= 32'd1;
          c_cnt   <= core_n;
          c_state <= C_MUL;
        end
        C_MUL: begin
          if (c_cnt == 8'd0) c_state <= C_IDLE;
          else begin
            c_acc <= c_acc * {24'd0, c_cnt};
            c_cnt <= c_cnt - 8'd1;
          end
        end
        default: c_state <= C_IDLE;
      endcase
    end
  end

  assign core_done = (c_state == C_IDLE);
  assign core_fn   = c_acc;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    logic        prev_valid;
    logic        prev_start;
    logic        expect_drop;
    logic [31:0] h_fn;
    logic        h_ovf;
    logic [3:0]  h_tag;
    exp_t        e;
    prev_valid  = 1'b0;
    prev_start  = 1'b0;
    expect_drop = 1'b0;
    h_fn = '0; h_ovf = 1'b0; h_tag = '0;
    forever begin
      @(negedge clk);
      if (core_start) begin
        start_cnt++;
        chk("core_start_width", {63'd0, prev_start}, 64'd0);
      end
      prev_start = core_start;
      if (rst) begin
        prev_valid  = 1'b0;
        expect_drop = 1'b0;
        continue;
      end
      if (expect_drop) begin
        chk("resp_valid_drop", {63'd0, resp_valid}, 64'd0);
        expect_drop = 1'b0;
        prev_valid  = 1'b0;
      end else if (resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp_tag", {60'd0, resp_tag}, 64'hFFFF);
        end else begin
          e = exp_q[0];
          if (!prev_valid) begin
            if (e.lat != 0) chk("resp_latency", 64'(cyc), {32'd0, e.lat});
            h_fn = resp_fn; h_ovf = resp_ovf; h_tag = resp_tag;
          end else begin
            chk("hold_fn",  {32'd0, resp_fn},  {32'd0, h_fn});
            chk("hold_ovf", {63'd0, resp_ovf}, {63'd0, h_ovf});
            chk("hold_tag", {60'd0, resp_tag}, {60'd0, h_tag});
          end
          if (resp_ready) begin
            void'(exp_q.pop_front());
            chk("resp_fn",  {32'd0, resp_fn},  {32'd0, e.fn});
            chk("resp_ovf", {63'd0, resp_ovf}, {63'd0, e.ovf});
            chk("resp_tag", {60'd0, resp_tag}, {60'd0, e.tag});
            expect_drop = 1'b1;
          end
        end
        prev_valid = resp_valid && !resp_ready;
      end else begin
        prev_valid = 1'b0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] n, input logic [3:0] tag, input logic [31:0] efn,
                      input logic eovf, input bit keep, input bit chk_lat);
    int   w;
    exp_t e;
    req_valid = 1'b1;
    req_n     = n;
    req_tag   = tag;
    w = 0;
    while (!req_ready && w < 400) begin
      tick();
      w++;
    end
    chk("req_accept", {63'd0, req_ready}, 64'd1);
    if (keep) begin
      e.fn  = efn;
      e.ovf = eovf;
      e.tag = tag;
      e.lat = chk_lat ? ((n == 8'd0 || n > 8'd12) ? 32'(cyc + 2) : 32'(cyc + 6 + int'(n))) : 32'd0;
      exp_q.push_back(e);
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < budget) begin
      tick();
      w++;
    end
    chk("drain_queue", 64'(exp_q.size()), 64'd0);
    repeat (3) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int          s0;
    int          w;
    logic [31:0] facts [6];
    facts[0] = 32'd1;  facts[1] = 32'd2;   facts[2] = 32'd6;
    facts[3] = 32'd24; facts[4] = 32'd120; facts[5] = 32'd720;
    checks = 0; errors = 0; start_cnt = 0;
    rst = 1'b1; req_valid = 1'b0; req_n = '0; req_tag = '0; resp_ready = 1'b1;
    fork
      monitor();
    join_none
    repeat (3) tick();
    chk("rst_req_ready",  {63'd0, req_ready},  64'd0);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_core_start", {63'd0, core_start}, 64'd0);
    chk("rst_core_n",     {56'd0, core_n},     64'd0);
    chk("rst_resp_fn",    {32'd0, resp_fn},    64'd0);
    chk("rst_resp_ovf",   {63'd0, resp_ovf},   64'd0);
    chk("rst_resp_tag",   {60'd0, resp_tag},   64'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", {63'd0, req_ready}, 64'd1);

    // core path, n=5
    s0 = start_cnt;
    send(8'd5, 4'd3, 32'd120, 1'b0, 1'b1, 1'b1);
    drain(100);
    chk("starts_n5", 64'(start_cnt - s0), 64'd1);

    // bypass n=0
    s0 = start_cnt;
    send(8'd0, 4'd1, 32'd1, 1'b0, 1'b1, 1'b1);
    drain(100);
    chk("starts_n0", 64'(start_cnt - s0), 64'd0);

    // boundary MAX_N and overflow
    send(8'd12, 4'd2, 32'd479001600, 1'b0, 1'b1, 1'b1);
    drain(100);
    s0 = start_cnt;
    send(8'd13, 4'd4, 32'd0, 1'b1, 1'b1, 1'b1);
    drain(100);
    chk("starts_n13", 64'(start_cnt - s0), 64'd0);
    send(8'd255, 4'd5, 32'd0, 1'b1, 1'b1, 1'b1);
    drain(100);

    // FIFO fill and ordering under back-pressure
    resp_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      send(8'(i + 1), 4'(i), facts[i], 1'b0, 1'b1, 1'b0);
    req_valid = 1'b1; req_n = 8'd6; req_tag = 4'd5;
    chk("fifo_full_ready_a", {63'd0, req_ready}, 64'd0);
    repeat (20) tick();
    chk("fifo_full_ready_b", {63'd0, req_ready}, 64'd0);
    resp_ready = 1'b1;
    send(8'd6, 4'd5, facts[5], 1'b0, 1'b1, 1'b0);
    drain(400);

    // response held under back-pressure
    resp_ready = 1'b0;
    send(8'd4, 4'd6, 32'd24, 1'b0, 1'b1, 1'b1);
    w = 0;
    while (!resp_valid && w < 100) begin
      tick();
      w++;
    end
    chk("bp_valid_seen", {63'd0, resp_valid}, 64'd1);
    repeat (10) tick();
    resp_ready = 1'b1;
    drain(50);

    // reset while the core is running with two requests queued
    send(8'd10, 4'd7, 32'd0, 1'b0, 1'b0, 1'b0);
    send(8'd7,  4'd8, 32'd0, 1'b0, 1'b0, 1'b0);
    send(8'd8,  4'd9, 32'd0, 1'b0, 1'b0, 1'b0);
    w = 0;
    while (dbg_state != 3'd3 && w < 100) begin
      tick();
      w++;
    end
    chk("reached_wait_done", {61'd0, dbg_state}, 64'd3);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("mid_rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("mid_rst_req_ready",  {63'd0, req_ready},  64'd1);
    chk("mid_rst_state",      {61'd0, dbg_state},  64'd0);
    s0 = start_cnt;
    repeat (40) tick();
    chk("mid_rst_no_starts", 64'(start_cnt - s0), 64'd0);
    send(8'd3, 4'd10, 32'd6, 1'b0, 1'b1, 1'b1);
    drain(100);
    repeat (20) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fact_req_seq.md
Name: fact_req_seq

Overview:
- Request sequencer that sits directly upstream and downstream of the iterative factorial core.
- Accepts n values through a valid/ready request port and buffers them in a small FIFO.
- Issues each n to the core via its start/done handshake, captures fn, and returns it through a valid/ready response port with a tag and an overflow flag.
- Handles n=0 and n>MAX_N locally. The core cannot terminate correctly on n=0, and n>MAX_N overflows FN_WIDTH.

Parameters:
- N_WIDTH, 8, width of n.
- FN_WIDTH, 32, width of result.
- TAG_WIDTH, 4, request tag width.
- DEPTH, 4, request FIFO entries (power of 2).
- MAX_N, 12, largest n whose factorial fits FN_WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset; also drives the core's rst.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO can accept.
- req_n  in  N_WIDTH  operand.
- req_tag  in  TAG_WIDTH  request tag.
- resp_valid  out  1  result present.
- resp_ready  in  1  consumer accepts.
- resp_fn  out  FN_WIDTH  n! (0 on overflow).
- resp_ovf  out  1  n>MAX_N.
- resp_tag  out  TAG_WIDTH  tag of the request.
- core_start  out  1  start pulse to core.
- core_n  out  N_WIDTH  operand to core.
- core_done  in  1  core idle/done level (high in core IDLE).
- core_fn  in  FN_WIDTH  core result register.

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - State goes to IDLE and the FIFO empties.
  - core_start=0, core_n=0, resp_valid=0, resp_fn=0, resp_ovf=0, resp_tag=0.
  - req_ready is forced 0 while rst is high.
- Request FIFO:
  - Push on req_valid&req_ready.
  - req_ready = !full, derived from registered count only; it does not depend on a same-cycle pop.
  - Push and pop in the same cycle is legal when not full.
  - Ordering is strictly FIFO.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE, FIFO non-empty, head n==0:
  - Pop the head.
  - Load resp_fn=1, resp_ovf=0, resp_tag=head tag.
  - Go to RESP.
- IDLE, FIFO non-empty, head n>MAX_N:
  - Pop the head.
  - Load resp_fn=0, resp_ovf=1, resp_tag=head tag.
  - Go to RESP.
  - The core is not started.
- IDLE, FIFO non-empty, 1<=n<=MAX_N, core_done=1:
  - Pop the head into n_reg and tag_reg.
  - Go to ISSUE.
  - If core_done=0, stay in IDLE and do not pop.
- ISSUE:
  - core_start=1 for exactly this one cycle.
  - Go to WAIT_BUSY.
- WAIT_BUSY: go to WAIT_DONE when core_done=0; otherwise wait.
- WAIT_DONE:
  - When core_done=1, capture resp_fn=core_fn, resp_ovf=0, resp_tag=tag_reg.
  - Go to RESP.
- RESP:
  - resp_valid=1.
  - resp_fn, resp_ovf and resp_tag are held stable until resp_valid&resp_ready.
  - On the handshake, go to IDLE. The next request is not examined in that same cycle.
- core_n is driven from n_reg and held stable from ISSUE through WAIT_DONE. The core samples n the cycle after start.
- Latency, empty FIFO, idle core, resp_ready=1. Let c0 be the request accept cycle.
  - Core path: resp_valid is high in cycle c0+6+n.
  - Bypass path (n=0 or n>MAX_N): resp_valid is high in c0+2.
- Throughput: one request in flight; the FIFO absorbs bursts.
- Reset mid-operation: the sequencer and core return to idle together. In-flight and queued requests are discarded and no response is produced for them.
- All arithmetic is unsigned. The n comparisons use N_WIDTH-bit values.

Test Plan:
- n=5, tag=3, resp_ready=1 → resp_fn=120, resp_ovf=0, resp_tag=3, resp_valid in c0+11; core_start high for exactly 1 cycle.
- n=0 → resp_fn=1, resp_ovf=0 in c0+2; core_start never asserted.
- n=12 → resp_fn=479001600, resp_ovf=0. n=13 → resp_fn=0, resp_ovf=1, no core_start. n=255 → resp_fn=0, resp_ovf=1.
- FIFO fill and ordering:
  - Stimulus: resp_ready=0, push n=1..6 with tags 0..5 back-to-back.
  - The first request is popped; the next 4 fill the FIFO; req_ready=0 while the 6th is offered.
  - Then raise resp_ready.
  - Required: responses in order with tags 0..5 and fn=1,2,6,24,120,720; the 6th is accepted once space frees.
- Back-pressure: n=4, resp_ready low for 10 cycles after resp_valid → resp_fn=24 and resp_tag stable throughout; single handshake; resp_valid drops the next cycle.
- Reset mid-run:
  - Stimulus: assert rst while WAIT_DONE for n=10 with 2 requests queued.
  - Required: the cycle after rst deasserts, resp_valid=0, FIFO empty, req_ready=1.
  - Then n=3 → resp_fn=6, and no stale responses appear.
